// File: rtl/synth_frame_loader.sv
// Frame loader: assembles SPI bytes into a shadow synth_t and commits whole frames atomically.
// Build option: define FRAME_CRC_EN to expect a trailing CRC-8 (poly 0x07) byte per frame.

package protocol_pkg;

    localparam int unsigned NUM_WAVE_GENS = 2;

    typedef enum logic [1:0] {
        SQUARE = 2'd0,
        SAW    = 2'd1,
        SIN    = 2'd2,
        TRI    = 2'd3
    } shape_e;

    typedef struct packed {
        logic [31:0] freq;
        shape_e      shape;
    } wave_gen_t;

    typedef struct packed {
        wave_gen_t [NUM_WAVE_GENS-1:0] wave_gens;
        logic [31:0]                   volume;
    } synth_t;

    function automatic synth_t reset_synth_t();
        synth_t r;
        r = '0;
        for (int i = 0; i < int'(NUM_WAVE_GENS); i++) begin
            r.wave_gens[i].shape = SIN;
        end
        return r;
    endfunction

endpackage

module synth_frame_loader
    import protocol_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        frame_end,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output synth_t      synth_out,
    output logic        synth_update,
    output logic        busy,
    output logic [7:0]  frame_err_cnt
);

    localparam int unsigned P = $bits(synth_t);
    localparam int unsigned B = (P + 7) / 8;
`ifdef FRAME_CRC_EN
    localparam int unsigned NBYTES = B + 1;
`else
    localparam int unsigned NBYTES = B;
`endif
    localparam int unsigned SAT = NBYTES + 1;
    localparam int unsigned CW  = $clog2(SAT + 1);
    localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_COMMIT,
        S_ERR
    } state_e;

    state_e          state_q, state_d;
    logic [P-1:0]    shadow_q, shadow_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_b;
    logic [TW-1:0]   idle_q, idle_d;
    synth_t          synth_q, synth_d;
    logic            upd_q, upd_d;
    logic            busy_q;
    logic [7:0]      err_q, err_d;
    logic            take, frame_ok, err_inc;

`ifdef FRAME_CRC_EN
    logic [7:0] crc_q, crc_d, crc_b;

    // MSB-first CRC-8, one byte per call; a correct trailing CRC drives the remainder to zero.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shadow_q <= '0;
            cnt_q    <= '0;
            idle_q   <= '0;
            synth_q  <= reset_synth_t();
            upd_q    <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 8'd0;
`ifdef FRAME_CRC_EN
            crc_q    <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            idle_q   <= idle_d;
            synth_q  <= synth_d;
            upd_q    <= upd_d;
            busy_q   <= (state_d == S_RECV);
            err_q    <= err_d;
`ifdef FRAME_CRC_EN
            crc_q    <= crc_d;
`endif
        end
    end

    // frame_start clears the frame context first so a coincident byte becomes byte 0.
    always_comb begin
        state_d  = state_q;
        synth_d  = synth_q;
        upd_d    = 1'b0;
        err_inc  = 1'b0;
        shadow_d = shadow_q;
        cnt_b    = frame_start ? '0 : cnt_q;
        cnt_d    = cnt_b;
        take     = byte_valid && (frame_start || (state_q == S_RECV));
        idle_d   = (frame_start || take) ? '0 : idle_q;
`ifdef FRAME_CRC_EN
        crc_b    = frame_start ? 8'd0 : crc_q;
        crc_d    = crc_b;
`endif

        if (take) begin
            // Shadow holds only the P payload bits; pad bits fall off the top.
            if (cnt_b < CW'(B)) begin
                shadow_d = {shadow_q[P-9:0], byte_data};
            end
`ifdef FRAME_CRC_EN
            if (cnt_b < CW'(NBYTES)) begin
                crc_d = crc8_step(crc_b, byte_data);
            end
`endif
            if (cnt_b != CW'(SAT)) begin
                cnt_d = cnt_b + CW'(1);
            end
        end else if (!frame_start && (state_q == S_RECV)) begin
            idle_d = idle_q + TW'(1);
        end

`ifdef FRAME_CRC_EN
        frame_ok = (cnt_d == CW'(NBYTES)) && (crc_d == 8'd0);
`else
        frame_ok = (cnt_d == CW'(NBYTES));
`endif

        case (state_q)
            S_RECV: begin
                if (frame_start) begin
                    err_inc = 1'b1;
                end else if (frame_end) begin
                    if (frame_ok) begin
                        state_d = S_COMMIT;
                        synth_d = synth_t'(shadow_d);
                        upd_d   = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_inc = 1'b1;
                    end
                end else if (!byte_valid && (idle_q == TW'(TIMEOUT_CYCLES - 1))) begin
                    state_d = S_ERR;
                    err_inc = 1'b1;
                end
            end
            default: begin
                state_d = frame_start ? S_RECV : S_IDLE;
            end
        endcase

        err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    end

    assign synth_out     = synth_q;
    assign synth_update  = upd_q;
    assign busy          = busy_q;
    assign frame_err_cnt = err_q;

endmodule

// File: doc/synth_frame_loader.md
# synth_frame_loader

Receives the MCU-to-FPGA control stream as a byte sequence from the SPI slave, assembles it into a shadow `synth_t` register, and atomically commits it to the live `synth_t` that drives the oscillators and effects. It sits between the SPI byte receiver and every consumer of `synth_t`. Partial, malformed or timed-out frames never reach the consumers.

## Interface
- `TIMEOUT_CYCLES`, default 4096: maximum idle gap between bytes inside a frame before the frame is aborted.
- `clk  in  1`: system clock; the only clock.
- `rst  in  1`: asynchronous, active-high reset.
- `frame_start  in  1`: single-cycle pulse on chip-select assertion.
- `frame_end  in  1`: single-cycle pulse on chip-select deassertion.
- `byte_valid  in  1`: `byte_data` is valid this cycle.
- `byte_data  in  8`: received byte, MSB first on the wire.
- `synth_out  out  $bits(synth_t)`: committed configuration, typed `protocol_pkg::synth_t`.
- `synth_update  out  1`: single-cycle pulse in the cycle in which a new `synth_out` first becomes visible.
- `busy  out  1`: high while a frame is being received.
- `frame_err_cnt  out  8`: saturating count of rejected frames.

## Operation
- Payload width is P = `$bits(synth_t)`. Byte count is B = ceil(P/8). Pad bits are 8B−P leading zero bits in the first byte.
- Bytes shift into a B×8-bit shadow register, left-shifting one byte per byte. The first byte lands in the most significant position, which matches packed `synth_t` order. On commit, `synth_out` takes the low P bits of the shadow register.
- A byte counter is clog2(B+2) bits wide and saturates at B+1.
- States:
  - IDLE
    - `frame_start` → RECV. Clear the counter, the CRC and the timeout counter.
    - Bytes or `frame_end` in IDLE are ignored.
  - RECV
    - Each `byte_valid` shifts the byte in, increments the counter and reloads the timeout counter.
    - `frame_end` with a correct count (and correct CRC when enabled) → COMMIT. Any other `frame_end` → ERR.
    - Timeout expiry → ERR.
  - COMMIT: copy shadow to `synth_out`, pulse `synth_update`, → IDLE.
  - ERR: increment `frame_err_cnt` (saturates at 255), leave `synth_out` untouched, → IDLE.
- Simultaneous events:
  - `byte_valid` together with `frame_end`: the byte is accepted first, then the end condition is evaluated including that byte.
  - `frame_start` together with `byte_valid`: the byte is the first byte of the new frame.
  - `frame_start` while in RECV: the partial frame counts as one error, and reception restarts immediately in the same cycle; there is no pass through ERR.
  - Bytes beyond the expected count are not shifted in. The counter saturates, so the frame fails at `frame_end`.
- Reset values:
  - `synth_out` equals the `reset_synth_t` value: all fields zero, except every `wave_gens[i].shape` = SIN.
  - `synth_update` = 0, `busy` = 0, `frame_err_cnt` = 0, state = IDLE.
  - Reset asserted mid-frame discards the frame and is not counted as an error.

## Timing
- `frame_end` sampled in cycle N: `synth_out` and `synth_update` change at cycle N+1 (COMMIT registered). Back in IDLE at N+2.
- `frame_start` is honoured in the COMMIT and ERR cycles: it goes straight to RECV, and the pending commit or error still completes.
- `busy` = 1 in RECV only.
- `synth_out` is stable except in the commit cycle; there is never a partial update.
- Timeout: abort occurs on the TIMEOUT_CYCLES-th consecutive cycle without `byte_valid` while in RECV.
- Accepted throughput is one byte per cycle.

## Configuration
- `FRAME_CRC_EN`
  - Defined: the frame is B+1 bytes. The last byte is a CRC-8 (polynomial 0x07, init 0x00, no reflection, no final XOR) over the B payload bytes. The CRC is computed serially per byte and is not shifted into the shadow register. A mismatch → ERR.
  - Undefined: the frame is exactly B bytes and no CRC logic is built.

## Test plan
- Reset check: `synth_out` has all shapes = SIN (2) and all other fields 0; `frame_err_cnt` = 0.
- Valid frame: send B bytes with `wave_gens[0].freq` = 0x0001_0000 and `volume` = 0x7FFF_FFFF, plus the correct CRC when `FRAME_CRC_EN` is defined; assert `frame_end` in cycle N.
  - Required response: `synth_update` pulses at N+1 with those field values, and `frame_err_cnt` stays 0.
- Short frame (B−1 bytes), then a long frame (B+5 bytes):
  - `frame_err_cnt` = 2.
  - `synth_out` unchanged; no `synth_update`.
- With `FRAME_CRC_EN`, send a valid frame with one payload bit flipped:
  - `frame_err_cnt` increments by 1.
  - `synth_out` holds the previous frame.
- Send 10 bytes, then idle TIMEOUT_CYCLES cycles, then a full valid frame:
  - One error is counted.
  - The second frame commits correctly.
- Edge cases, each exercised:
  - `frame_start` mid-frame: counts one error, and the restarted frame commits.
  - Last byte coincident with `frame_end`: the frame commits.
  - Async reset mid-frame: outputs return to their reset values immediately, and `frame_err_cnt` = 0.
